// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter for the shared 8-bit uio pad bus, with bounded hold time
// and an idle turnaround cycle before every ownership change.
module uio_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   dir,
    input  logic [8*NREQ-1:0] wdata,
    input  logic [7:0]        uio_in,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe,
    output logic [NREQ-1:0]   grant,
    output logic [7:0]        rdata,
    output logic              rvalid,
    output logic              busy
);
    // state | meaning
    // IDLE  | no owner; arbitrate when ena and any req
    // TURN  | one dead cycle, pads released, winner latched
    // OWN   | owner holds the bus until req drops or hold limit

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, TURN, OWN} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, owner, win, owner_inc;
    logic          odir, found, release_own;
    logic [7:0]    hold_cnt, out_nxt;
    int            idx;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    assign owner_inc   = (owner == IW'(NREQ-1)) ? '0 : owner + 1'b1;
    assign release_own = !req[owner] || (hold_cnt == 8'(MAX_HOLD));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ena && found) state_nxt = TURN;
            TURN:    state_nxt = OWN;
            OWN:     if (release_own) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pad data is registered so it reflects wdata from the previous edge.
    always_comb begin
        out_nxt = 8'h00;
        if (state_nxt == OWN && odir) out_nxt = wdata[int'(owner)*8 +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            odir     <= 1'b0;
            hold_cnt <= 8'h00;
            uio_out  <= 8'h00;
            rdata    <= 8'h00;
            rvalid   <= 1'b0;
        end else begin
            state   <= state_nxt;
            uio_out <= out_nxt;
            case (state)
                IDLE: if (ena && found) begin
                    owner <= win;
                    odir  <= dir[win];
                end
                TURN: hold_cnt <= 8'd1;
                OWN: begin
                    if (release_own) ptr <= owner_inc;
                    else             hold_cnt <= hold_cnt + 8'd1;
                end
                default: ;
            endcase
            rvalid <= (state == OWN) && !odir;
            if ((state == OWN) && !odir) rdata <= uio_in;
        end
    end

    assign grant  = (state == OWN) ? (NREQ'(1) << owner) : '0;
    assign uio_oe = (state == OWN && odir) ? 8'hFF : 8'h00;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter: expected grants and read samples are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_uio_bus_arbiter;
    logic        clk, rst, ena;
    logic [3:0]  req, dir;
    logic [31:0] wdata;
    logic [7:0]  uio_in, uio_out, uio_oe, rdata;
    logic [3:0]  grant;
    logic        rvalid, busy;

    uio_bus_arbiter #(.NREQ(4), .MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst), .ena(ena), .req(req), .dir(dir), .wdata(wdata),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe), .grant(grant),
        .rdata(rdata), .rvalid(rvalid), .busy(busy)
    );

    typedef struct {
        logic [3:0] g;
        logic [7:0] oe;
        logic [7:0] out;
        int         len;   // -1: not checked
        int         gap;   // -1: not checked
    } gexp_t;

    gexp_t      exp_g[$];
    logic [7:0] exp_rd[$];
    int         ncmp = 0;
    int         nfail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input logic ok, input string nm, input int act, input int exp);
        ncmp++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic gexp_t mk(logic [3:0] g, logic [7:0] oe, logic [7:0] out, int len, int gap);
        gexp_t e;
        e.g = g; e.oe = oe; e.out = out; e.len = len; e.gap = gap;
        return e;
    endfunction

    // Monitor
    gexp_t cur;
    logic  in_grant = 1'b0;
    logic  have_cur = 1'b0;
    int    glen = 0;
    int    gap = 0;
    logic [7:0] rd_e;

    always @(negedge clk) begin
        if (rst) begin
            in_grant = 1'b0;
            have_cur = 1'b0;
            gap      = -1000;
        end else begin
            chk($onehot0(grant), "grant_onehot", int'(grant), 0);
            if (uio_oe != 8'h00) chk(grant != 4'b0, "oe_without_grant", int'(uio_oe), 0);
            if (grant != 4'b0) begin
                if (!in_grant) begin
                    if (exp_g.size() == 0) begin
                        chk(1'b0, "grant_unexpected", int'(grant), 0);
                        have_cur = 1'b0;
                    end else begin
                        cur = exp_g.pop_front();
                        have_cur = 1'b1;
                        chk(grant == cur.g, "grant_owner", int'(grant), int'(cur.g));
                        if (cur.gap >= 0) chk(gap == cur.gap, "turn_gap", gap, cur.gap);
                    end
                    in_grant = 1'b1;
                    glen = 0;
                end
                glen++;
                if (have_cur) begin
                    chk(uio_oe == cur.oe, "uio_oe_own", int'(uio_oe), int'(cur.oe));
                    chk(uio_out == cur.out, "uio_out_own", int'(uio_out), int'(cur.out));
                end
            end else begin
                if (in_grant) begin
                    if (have_cur && cur.len >= 0) chk(glen == cur.len, "grant_len", glen, cur.len);
                    in_grant = 1'b0;
                    gap = 0;
                end
                gap++;
                chk(uio_oe == 8'h00 && uio_out == 8'h00, "pads_idle", int'({uio_oe, uio_out}), 0);
            end
            if (rvalid) begin
                if (exp_rd.size() == 0) chk(1'b0, "rvalid_unexpected", int'(rdata), 0);
                else begin
                    rd_e = exp_rd.pop_front();
                    chk(rdata == rd_e, "rdata", int'(rdata), int'(rd_e));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; req = 4'b0; dir = 4'b0; wdata = 32'h0; uio_in = 8'h00;
        #1;
        chk(grant == 4'b0 && busy == 1'b0, "reset_grant_busy", int'({busy, grant}), 0);
        chk(uio_oe == 8'h00 && uio_out == 8'h00, "reset_pads", int'({uio_oe, uio_out}), 0);
        chk(rdata == 8'h00 && rvalid == 1'b0, "reset_rdata", int'({rvalid, rdata}), 0);
        step(3);
        rst = 1'b0;
        step(2);

        // Single write owner, dropped after two OWN cycles
        exp_g.push_back(mk(4'b0001, 8'hFF, 8'hA5, 2, -1));
        req = 4'b0001; dir = 4'b0001; wdata = 32'h0000_00A5;   // N0
        step(1);
        chk(grant == 4'b0, "latency_edge1", int'(grant), 0);
        step(1);
        chk(grant == 4'b0001, "latency_edge2", int'(grant), 1);
        step(1);
        req = 4'b0000;                                          // N3
        step(1);
        chk(grant == 4'b0 && uio_oe == 8'h00, "drop_release", int'({uio_oe, grant}), 0);
        step(4);

        // Round robin from ptr=0 with everyone requesting
        rst = 1'b1; step(2); rst = 1'b0; step(2);
        exp_g.push_back(mk(4'b0001, 8'hFF, 8'h11, 8, -1));
        exp_g.push_back(mk(4'b0010, 8'hFF, 8'h22, 8, 2));
        exp_g.push_back(mk(4'b0100, 8'hFF, 8'h33, 8, 2));
        exp_g.push_back(mk(4'b1000, 8'hFF, 8'h44, 8, 2));
        exp_g.push_back(mk(4'b0001, 8'hFF, 8'h11, 1, 2));
        req = 4'b1111; dir = 4'b1111; wdata = 32'h4433_2211;   // N0
        step(42);
        req = 4'b0000;                                          // N42
        step(5);

        // Read owner 2 with a ramping pad input
        exp_g.push_back(mk(4'b0100, 8'h00, 8'h00, 4, -1));
        for (int v = 2; v <= 5; v++) exp_rd.push_back(8'(v));
        req = 4'b0100; dir = 4'b0000; uio_in = 8'h00;           // N0
        for (int k = 1; k <= 8; k++) begin
            step(1);
            uio_in = 8'(k);
            if (k == 5) req = 4'b0000;
        end
        step(3);

        // ena gating
        ena = 1'b0; req = 4'b0010; dir = 4'b0010; wdata = 32'h0000_5A00;
        step(5);
        chk(grant == 4'b0 && busy == 1'b0, "ena_low_blocks", int'({busy, grant}), 0);
        exp_g.push_back(mk(4'b0010, 8'hFF, 8'h5A, 8, -1));
        ena = 1'b1;                                             // N0
        step(2);
        chk(grant == 4'b0010, "ena_rise_grant", int'(grant), 2);
        step(1);
        ena = 1'b0;                                             // N3
        step(11);
        chk(busy == 1'b0 && grant == 4'b0, "ena_low_wait", int'({busy, grant}), 0);
        req = 4'b0000; ena = 1'b1;
        step(3);

        // Reset in the middle of a write grant
        exp_g.push_back(mk(4'b0001, 8'hFF, 8'h3C, -1, -1));
        req = 4'b0001; dir = 4'b0001; wdata = 32'h0000_003C;   // N0
        step(4);
        chk(uio_oe == 8'hFF && uio_out == 8'h3C, "pre_reset_drive", int'({uio_oe, uio_out}), 16'hFF3C);
        rst = 1'b1;
        #1;
        chk(uio_oe == 8'h00 && uio_out == 8'h00 && grant == 4'b0, "async_reset_pads",
            int'({uio_oe, uio_out, grant}), 0);
        req = 4'b0000;
        step(2);
        rst = 1'b0;
        step(2);
        exp_g.push_back(mk(4'b0010, 8'hFF, 8'h77, 8, -1));
        req = 4'b0110; dir = 4'b0110; wdata = 32'h0099_7700;   // N0
        step(10);
        req = 4'b0000;                                          // N10
        step(4);

        // Direction toggle during OWN is ignored
        exp_g.push_back(mk(4'b0001, 8'hFF, 8'hC3, 4, -1));
        req = 4'b0001; dir = 4'b0001; wdata = 32'h0000_00C3;   // N0
        step(3);
        dir = 4'b0000;                                          // N3
        step(2);
        req = 4'b0000;                                          // N5
        step(5);

        chk(exp_g.size() == 0, "grants_outstanding", exp_g.size(), 0);
        chk(exp_rd.size() == 0, "reads_outstanding", exp_rd.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
